// File: rtl/trellis_sched_pkg.sv
// Shared types and constants for the Viterbi survivor-memory bank scheduler.
// Holds bank/state enums, display counter reset constants and the TBU routing table.
package trellis_sched_pkg;

   typedef enum logic [1:0] {
      BANK_A = 2'd0,
      BANK_B = 2'd1,
      BANK_C = 2'd2,
      BANK_D = 2'd3
   } bank_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int DISP_WR_INIT     = 2;
   localparam int DISP_RD_INIT_OFS = 3;

   // Each field packs TBU1 in the upper half and TBU0 in the lower half.
   typedef struct packed {
      logic [3:0] src0;
      logic [3:0] src1;
      logic [1:0] sel;
   } tbu_route_t;

   function automatic tbu_route_t tbu_route(input bank_t b2);
      tbu_route_t r;
      r = '0;
      case (b2)
         BANK_A: begin
            r.src0 = {BANK_C, BANK_D};
            r.src1 = {BANK_B, BANK_C};
            r.sel  = 2'b10;
         end
         BANK_B: begin
            r.src0 = {BANK_A, BANK_D};
            r.src1 = {BANK_D, BANK_C};
            r.sel  = 2'b01;
         end
         BANK_C: begin
            r.src0 = {BANK_A, BANK_B};
            r.src1 = {BANK_D, BANK_A};
            r.sel  = 2'b10;
         end
         default: begin
            r.src0 = {BANK_C, BANK_B};
            r.src1 = {BANK_B, BANK_A};
            r.sel  = 2'b01;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/trellis_bank_dly.sv
// Shift register of bank indices; taps_o[0] is one cycle behind d_i, taps_o[DEPTH-1] is DEPTH cycles behind.
// Only cleared by the asynchronous reset, never by the run enable.
module trellis_bank_dly
   import trellis_sched_pkg::*;
#(
   parameter int DEPTH = 5
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  bank_t d_i,
   output bank_t taps_o [DEPTH]
);

   bank_t taps_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            taps_q[i] <= BANK_A;
         end
      end else begin
         taps_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            taps_q[i] <= taps_q[i-1];
         end
      end
   end

   assign taps_o = taps_q;

endmodule

// File: rtl/trellis_bank_sched.sv
// Survivor-memory sequencer: rotates banks A..D through write/traceback roles, drives both TBUs
// and the ping-pong display memories. Optional frame statistics: define TRELLIS_SCHED_STATS_EN.
module trellis_bank_sched
   import trellis_sched_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int DISP_ADDR_W = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   output logic [1:0]               wr_bank,
   output logic [3:0]               bank_wr_en,
   output logic [4*ADDR_W-1:0]      bank_addr,
   output logic                     frame_start,
   output logic [1:0]               tbu_en,
   output logic [1:0]               tbu_sel,
   output logic [3:0]               tbu_src0,
   output logic [3:0]               tbu_src1,
   output logic [2*DISP_ADDR_W-1:0] disp_addr,
   output logic                     out_sel,
   output logic [1:0]               state,
   output logic [15:0]              frame_cnt
);

   localparam logic [DISP_ADDR_W-1:0] DISP_WR_RST = DISP_ADDR_W'(DISP_WR_INIT);
   localparam logic [DISP_ADDR_W-1:0] DISP_RD_RST = DISP_ADDR_W'(0) - DISP_ADDR_W'(DISP_RD_INIT_OFS);

   logic [ADDR_W-1:0]        wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0]        rd_cnt_q, rd_cnt_d;
   bank_t                    wr_bank_q, wr_bank_d;
   logic                     frame_start_q, frame_start_d;
   logic [3:0]               bank_wr_en_q, bank_wr_en_d;
   logic [4*ADDR_W-1:0]      bank_addr_q, bank_addr_d;
   logic [1:0]               tbu_en_q, tbu_en_d;
   tbu_route_t               tbu_q, tbu_d;
   logic [DISP_ADDR_W-1:0]   disp_wr_q, disp_wr_d;
   logic [DISP_ADDR_W-1:0]   disp_rd_q, disp_rd_d;
   logic [2*DISP_ADDR_W-1:0] disp_addr_q, disp_addr_d;
   logic                     out_sel_q, out_sel_d;
   state_t                   state_q;

   bank_t dly_taps [5];
   logic  rotate;
   logic  unused_taps;

   trellis_bank_dly #(
      .DEPTH (5)
   ) u_dly (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (wr_bank_q),
      .taps_o (dly_taps)
   );

   assign rotate      = (wr_cnt_q == '1);
   assign unused_taps = ^{dly_taps[2][1], dly_taps[3][1], dly_taps[4]};

   // Every default below is the flush value, so !enable needs no separate branch.
   always_comb begin
      logic [1:0] rel;
      rel           = '0;
      wr_cnt_d      = '0;
      rd_cnt_d      = '1;
      wr_bank_d     = BANK_A;
      frame_start_d = 1'b0;
      bank_wr_en_d  = 4'b0001;
      bank_addr_d   = '0;
      tbu_en_d      = '0;
      tbu_d         = '0;
      disp_wr_d     = DISP_WR_RST;
      disp_rd_d     = DISP_RD_RST;
      disp_addr_d   = '0;
      out_sel_d     = 1'b0;
      if (enable) begin
         wr_cnt_d      = wr_cnt_q + ADDR_W'(1);
         rd_cnt_d      = rd_cnt_q - ADDR_W'(1);
         wr_bank_d     = rotate ? bank_t'(wr_bank_q + 2'd1) : wr_bank_q;
         frame_start_d = rotate;
         bank_wr_en_d  = 4'b0001 << wr_bank_q;
         for (int i = 0; i < 4; i++) begin
            rel = 2'(i) - wr_bank_q;
            case (rel)
               2'd0:    bank_addr_d[i*ADDR_W +: ADDR_W] = wr_cnt_q;
               2'd2:    bank_addr_d[i*ADDR_W +: ADDR_W] = '0;
               default: bank_addr_d[i*ADDR_W +: ADDR_W] = rd_cnt_q;
            endcase
         end
         tbu_d     = tbu_route(dly_taps[1]);
         tbu_en_d  = tbu_en_q | {dly_taps[1] == BANK_D, dly_taps[1] == BANK_C};
         disp_wr_d = disp_wr_q - DISP_ADDR_W'(1);
         disp_rd_d = disp_rd_q + DISP_ADDR_W'(1);
         disp_addr_d = dly_taps[2][0] ? {disp_rd_q, disp_wr_q} : {disp_wr_q, disp_rd_q};
         // Registering b4 makes out_sel coincide with b5 while running yet still clear on flush.
         out_sel_d = dly_taps[3][0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '1;
         wr_bank_q     <= BANK_A;
         frame_start_q <= 1'b0;
         bank_wr_en_q  <= 4'b0001;
         bank_addr_q   <= '0;
         tbu_en_q      <= '0;
         tbu_q         <= '0;
         disp_wr_q     <= DISP_WR_RST;
         disp_rd_q     <= DISP_RD_RST;
         disp_addr_q   <= '0;
         out_sel_q     <= 1'b0;
      end else begin
         wr_cnt_q      <= wr_cnt_d;
         rd_cnt_q      <= rd_cnt_d;
         wr_bank_q     <= wr_bank_d;
         frame_start_q <= frame_start_d;
         bank_wr_en_q  <= bank_wr_en_d;
         bank_addr_q   <= bank_addr_d;
         tbu_en_q      <= tbu_en_d;
         tbu_q         <= tbu_d;
         disp_wr_q     <= disp_wr_d;
         disp_rd_q     <= disp_rd_d;
         disp_addr_q   <= disp_addr_d;
         out_sel_q     <= out_sel_d;
      end
   end

   // FILL leaves as soon as TBU0 is (or becomes) enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (!enable) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    state_q <= FILL;
            FILL:    state_q <= tbu_en_d[0] ? RUN : FILL;
            RUN:     state_q <= RUN;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TRELLIS_SCHED_STATS_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (!enable) begin
         frame_cnt_q <= '0;
      end else if (rotate && (state_q == RUN) && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = '0;
`endif

   assign wr_bank     = wr_bank_q;
   assign frame_start = frame_start_q;
   assign bank_wr_en  = bank_wr_en_q;
   assign bank_addr   = bank_addr_q;
   assign tbu_en      = tbu_en_q;
   assign tbu_sel     = tbu_q.sel;
   assign tbu_src0    = tbu_q.src0;
   assign tbu_src1    = tbu_q.src1;
   assign disp_addr   = disp_addr_q;
   assign out_sel     = out_sel_q;
   assign state       = state_q;

   a_wr_en_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(bank_wr_en_q));
   a_state_legal:  assert property (@(posedge clk) disable iff (rst) state_q != 2'd3);

endmodule

// File: tb/tb_trellis_bank_sched.sv
// Directed bench for trellis_bank_sched: vector table over one continuous run plus
// hand-written reset, flush, re-enable and flush-at-rotation sequences.
module tb_trellis_bank_sched;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  wr_bank;
   logic [3:0]  bank_wr_en;
   logic [39:0] bank_addr;
   logic        frame_start;
   logic [1:0]  tbu_en;
   logic [1:0]  tbu_sel;
   logic [3:0]  tbu_src0;
   logic [3:0]  tbu_src1;
   logic [19:0] disp_addr;
   logic        out_sel;
   logic [1:0]  state;
   logic [15:0] frame_cnt;

   int n_checks;
   int n_errors;
   int edge_cnt;

   typedef struct {
      int          k;
      logic [1:0]  wb;
      logic [3:0]  wen;
      logic [9:0]  a, b, c, d;
      logic        fs;
      logic [1:0]  ten;
      logic [3:0]  s0, s1;
      logic [1:0]  sel;
      logic [1:0]  st;
      logic [9:0]  dlo, dhi;
      logic        os;
      logic [15:0] fc;
   } vec_t;

   vec_t vecs [15];

   trellis_bank_sched #(
      .ADDR_W      (10),
      .DISP_ADDR_W (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .wr_bank     (wr_bank),
      .bank_wr_en  (bank_wr_en),
      .bank_addr   (bank_addr),
      .frame_start (frame_start),
      .tbu_en      (tbu_en),
      .tbu_sel     (tbu_sel),
      .tbu_src0    (tbu_src0),
      .tbu_src1    (tbu_src1),
      .disp_addr   (disp_addr),
      .out_sel     (out_sel),
      .state       (state),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string name);
      chk(name,
          {wr_bank, bank_wr_en, bank_addr, frame_start, tbu_en, tbu_src0, tbu_src1, tbu_sel,
           disp_addr, out_sel, state, frame_cnt},
          {2'd0, 4'b0001, 40'd0, 1'b0, 2'd0, 4'd0, 4'd0, 2'd0, 20'd0, 1'b0, 2'd0, 16'd0});
   endtask

   initial begin
      logic [15:0] fc_exp;
      n_checks = 0;
      n_errors = 0;
      edge_cnt = 0;

      //         k     wb  wen      A     B     C     D     fs ten    s0    s1    sel    st  dlo   dhi   os  fc
      vecs[0]  = '{1,    0, 4'b0001, 0,    1023, 0,    1023, 0, 2'b00, 4'hB, 4'h6, 2'b10, 1, 1021, 2,    0, 0};
      vecs[1]  = '{2,    0, 4'b0001, 1,    1022, 0,    1022, 0, 2'b00, 4'hB, 4'h6, 2'b10, 1, 1022, 1,    0, 0};
      vecs[2]  = '{4,    0, 4'b0001, 3,    1020, 0,    1020, 0, 2'b00, 4'hB, 4'h6, 2'b10, 1, 0,    1023, 0, 0};
      vecs[3]  = '{1023, 0, 4'b0001, 1022, 1,    0,    1,    0, 2'b00, 4'hB, 4'h6, 2'b10, 1, 1019, 4,    0, 0};
      vecs[4]  = '{1024, 1, 4'b0001, 1023, 0,    0,    0,    1, 2'b00, 4'hB, 4'h6, 2'b10, 1, 1020, 3,    0, 0};
      vecs[5]  = '{1025, 1, 4'b0010, 1023, 0,    1023, 0,    0, 2'b00, 4'hB, 4'h6, 2'b10, 1, 1021, 2,    0, 0};
      vecs[6]  = '{1027, 1, 4'b0010, 1021, 2,    1021, 0,    0, 2'b00, 4'h3, 4'hE, 2'b01, 1, 1023, 0,    0, 0};
      vecs[7]  = '{1028, 1, 4'b0010, 1020, 3,    1020, 0,    0, 2'b00, 4'h3, 4'hE, 2'b01, 1, 1023, 0,    0, 0};
      vecs[8]  = '{1029, 1, 4'b0010, 1019, 4,    1019, 0,    0, 2'b00, 4'h3, 4'hE, 2'b01, 1, 1022, 1,    1, 0};
      vecs[9]  = '{2048, 2, 4'b0010, 0,    1023, 0,    0,    1, 2'b00, 4'h3, 4'hE, 2'b01, 1, 3,    1020, 1, 0};
      vecs[10] = '{2050, 2, 4'b0100, 0,    1022, 1,    1022, 0, 2'b00, 4'h3, 4'hE, 2'b01, 1, 1,    1022, 1, 0};
      vecs[11] = '{2051, 2, 4'b0100, 0,    1021, 2,    1021, 0, 2'b01, 4'h1, 4'hC, 2'b10, 2, 0,    1023, 1, 0};
      vecs[12] = '{3075, 3, 4'b1000, 1021, 0,    1021, 2,    0, 2'b11, 4'h9, 4'h4, 2'b01, 2, 1023, 0,    0, 1};
      vecs[13] = '{4096, 0, 4'b1000, 0,    0,    0,    1023, 1, 2'b11, 4'h9, 4'h4, 2'b01, 2, 3,    1020, 1, 2};
      vecs[14] = '{4097, 0, 4'b0001, 0,    1023, 0,    1023, 0, 2'b11, 4'h9, 4'h4, 2'b01, 2, 2,    1021, 1, 2};

      rst    = 1'b1;
      enable = 1'b0;
      #2;
      chk_reset("reset_async");
      #6;
      rst = 1'b0;
      step();
      chk_reset("idle_disabled");

      enable   = 1'b1;
      edge_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         while (edge_cnt < vecs[i].k) step();
`ifdef TRELLIS_SCHED_STATS_EN
         fc_exp = vecs[i].fc;
`else
         fc_exp = 16'd0;
`endif
         chk($sformatf("bank_k%0d", vecs[i].k),
             {wr_bank, bank_wr_en, bank_addr, frame_start},
             {vecs[i].wb, vecs[i].wen, vecs[i].d, vecs[i].c, vecs[i].b, vecs[i].a, vecs[i].fs});
         chk($sformatf("tbu_k%0d", vecs[i].k),
             {tbu_en, tbu_src0, tbu_src1, tbu_sel},
             {vecs[i].ten, vecs[i].s0, vecs[i].s1, vecs[i].sel});
         chk($sformatf("disp_k%0d", vecs[i].k),
             {disp_addr, out_sel},
             {vecs[i].dhi, vecs[i].dlo, vecs[i].os});
         chk($sformatf("ctl_k%0d", vecs[i].k), {state, frame_cnt}, {vecs[i].st, fc_exp});
      end

      // Asynchronous reset in the middle of a clock period while running.
      #3;
      rst = 1'b1;
      #1;
      chk_reset("rst_mid_run");
      #1;
      rst      = 1'b0;
      edge_cnt = 0;

      // Flush at wr_cnt=500 in bank C.
      while (edge_cnt < 2548) step();
      chk("pre_flush", {wr_bank, tbu_en, state, bank_addr[29:20]}, {2'd2, 2'b01, 2'd2, 10'd499});
      enable = 1'b0;
      step();
      chk_reset("flush_mid_frame");
      repeat (6) step();

      enable   = 1'b1;
      edge_cnt = 0;
      step();
      chk("reenable_1", {state, wr_bank, bank_wr_en, bank_addr[9:0]}, {2'd1, 2'd0, 4'b0001, 10'd0});
      step();
      chk("reenable_2", {bank_addr[9:0], bank_addr[39:30]}, {10'd1, 10'd1022});

      // Flush on the very edge that would rotate the bank.
      while (edge_cnt < 1023) step();
      enable = 1'b0;
      step();
      chk_reset("flush_at_rotation");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
